// File: rtl/sdram_arbiter.sv
// Slot-based SDRAM arbiter: one owner (LDR, CPU, PPU or an idle refresh slot)
// per 16-clock memory slot, with CPU anti-starvation and forced refresh slots.
module sdram_arbiter #(
   parameter int unsigned REFRESH_INTERVAL = 32,
   parameter int unsigned STARVE_LIMIT     = 2,
   parameter int unsigned DATA_PHASE       = 9
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        slot_start,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [24:0] cpu_addr,
   input  logic [7:0]  cpu_din,
   output logic        cpu_ack,
   output logic [7:0]  cpu_dout,
   input  logic        ppu_req,
   input  logic [24:0] ppu_addr,
   output logic        ppu_ack,
   output logic [7:0]  ppu_dout,
   input  logic        ldr_req,
   input  logic [24:0] ldr_addr,
   input  logic [7:0]  ldr_din,
   output logic        ldr_ack,
   output logic [24:0] mem_addr,
   output logic [7:0]  mem_din,
   output logic        mem_we,
   output logic        mem_oeA,
   output logic        mem_oeB,
   input  logic [7:0]  mem_doutA,
   input  logic [7:0]  mem_doutB
);

   typedef enum logic [1:0] {OWN_IDLE, OWN_LDR, OWN_CPU, OWN_PPU} owner_t;

   owner_t      owner, owner_next;
   logic [3:0]  phase;
   logic [1:0]  cpu_wait;
   logic [5:0]  refresh_cnt;
   logic        cpu_write;
   logic        refresh_due;
   logic        data_edge;

   // Next-owner selection; only meaningful on a slot_start edge.
   always_comb begin
      owner_next  = owner;
      refresh_due = (refresh_cnt == 6'(REFRESH_INTERVAL - 1));
      data_edge   = !slot_start && (phase == 4'(DATA_PHASE - 1));
      if (slot_start) begin
         if (refresh_due)
            owner_next = OWN_IDLE;
         else if (ldr_req)
            owner_next = OWN_LDR;
         else if (cpu_req && (32'(cpu_wait) >= STARVE_LIMIT))
            owner_next = OWN_CPU;
         else if (ppu_req)
            owner_next = OWN_PPU;
         else if (cpu_req)
            owner_next = OWN_CPU;
         else
            owner_next = OWN_IDLE;
      end
   end

   // Owner, slot phase, starvation and refresh bookkeeping.
   always_ff @(posedge clk) begin
      if (reset) begin
         owner       <= OWN_IDLE;
         phase       <= 4'hF;
         cpu_wait    <= '0;
         refresh_cnt <= '0;
         cpu_write   <= 1'b0;
      end else begin
         owner <= owner_next;
         if (slot_start) begin
            phase     <= 4'd1;
            cpu_write <= cpu_we;
            if (cpu_req && owner_next != OWN_CPU)
               cpu_wait <= (cpu_wait == 2'b11) ? cpu_wait : cpu_wait + 2'd1;
            else
               cpu_wait <= '0;
            // Counts completed granted slots; an idle slot restarts the run.
            if (owner_next == OWN_IDLE)
               refresh_cnt <= '0;
            else if (owner != OWN_IDLE)
               refresh_cnt <= refresh_cnt + 6'd1;
         end else if (phase != 4'hF) begin
            phase <= phase + 4'd1;
         end
      end
   end

   // Registered command port, acks and read-data capture.
   always_ff @(posedge clk) begin
      if (reset) begin
         mem_we   <= 1'b0;
         mem_oeA  <= 1'b0;
         mem_oeB  <= 1'b0;
         mem_addr <= '0;
         mem_din  <= '0;
         cpu_ack  <= 1'b0;
         ppu_ack  <= 1'b0;
         ldr_ack  <= 1'b0;
         cpu_dout <= '0;
         ppu_dout <= '0;
      end else begin
         cpu_ack <= 1'b0;
         ppu_ack <= 1'b0;
         ldr_ack <= 1'b0;
         if (slot_start) begin
            mem_we  <= 1'b0;
            mem_oeA <= 1'b0;
            mem_oeB <= 1'b0;
            case (owner_next)
               OWN_LDR: begin
                  mem_we   <= 1'b1;
                  mem_addr <= ldr_addr;
                  mem_din  <= ldr_din;
               end
               OWN_CPU: begin
                  mem_addr <= cpu_addr;
                  if (cpu_we) begin
                     mem_we  <= 1'b1;
                     mem_din <= cpu_din;
                  end else begin
                     mem_oeA <= 1'b1;
                  end
               end
               OWN_PPU: begin
                  mem_oeB  <= 1'b1;
                  mem_addr <= ppu_addr;
               end
               default: ;
            endcase
         end else if (data_edge) begin
            case (owner)
               OWN_LDR: ldr_ack <= 1'b1;
               OWN_CPU: begin
                  cpu_ack <= 1'b1;
                  if (!cpu_write)
                     cpu_dout <= mem_doutA;
               end
               OWN_PPU: begin
                  ppu_ack  <= 1'b1;
                  ppu_dout <= mem_doutB;
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed self-checking bench for sdram_arbiter.
module tb_sdram_arbiter;

   localparam logic [24:0] CPU_R_A = 25'h0001234;
   localparam logic [24:0] CPU_W_A = 25'h1ABCDEF;
   localparam logic [24:0] PPU_A   = 25'h0000ABC;
   localparam logic [24:0] LDR_A   = 25'h0100000;

   logic        clk = 1'b0;
   logic        reset, slot_start;
   logic        cpu_req, cpu_we, cpu_ack, ppu_req, ppu_ack, ldr_req, ldr_ack;
   logic [24:0] cpu_addr, ppu_addr, ldr_addr, mem_addr;
   logic [7:0]  cpu_din, cpu_dout, ppu_dout, ldr_din, mem_din, mem_doutA, mem_doutB;
   logic        mem_we, mem_oeA, mem_oeB;

   int n_checks = 0;
   int n_fail   = 0;

   // per-slot observations
   logic        s_we, s_oeA, s_oeB;
   logic [24:0] s_addr;
   logic [7:0]  s_din;
   int n_cpu_ack, n_ppu_ack, n_ldr_ack, ack_ph, n_excl, n_chg, n_oeA;

   sdram_arbiter #(.REFRESH_INTERVAL(32), .STARVE_LIMIT(2), .DATA_PHASE(9)) dut (
      .clk(clk), .reset(reset), .slot_start(slot_start),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
      .cpu_ack(cpu_ack), .cpu_dout(cpu_dout),
      .ppu_req(ppu_req), .ppu_addr(ppu_addr), .ppu_ack(ppu_ack), .ppu_dout(ppu_dout),
      .ldr_req(ldr_req), .ldr_addr(ldr_addr), .ldr_din(ldr_din), .ldr_ack(ldr_ack),
      .mem_addr(mem_addr), .mem_din(mem_din), .mem_we(mem_we),
      .mem_oeA(mem_oeA), .mem_oeB(mem_oeB),
      .mem_doutA(mem_doutA), .mem_doutB(mem_doutB)
   );

   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // 0 idle, 1 loader, 2 cpu, 3 ppu, decoded from the phase-1 command
   function automatic int grant;
      if (s_oeB) return 3;
      if (s_oeA) return 2;
      if (s_we)  return (s_addr == LDR_A) ? 1 : 2;
      return 0;
   endfunction

   // One slot of len clocks; optionally perturbs request inputs mid-slot.
   task automatic run_slot(input int len, input bit mid);
      n_cpu_ack = 0; n_ppu_ack = 0; n_ldr_ack = 0;
      ack_ph = 0; n_excl = 0; n_chg = 0; n_oeA = 0;
      slot_start = 1'b1;
      tick;
      slot_start = 1'b0;
      s_we = mem_we; s_oeA = mem_oeA; s_oeB = mem_oeB; s_addr = mem_addr; s_din = mem_din;
      for (int i = 1; i <= len; i++) begin
         if (i > 1) tick;
         if (mid && i == 5) begin
            ldr_din ^= 8'hFF; cpu_din ^= 8'hFF; cpu_addr ^= 25'h1; ppu_addr ^= 25'h1;
         end
         if (mem_we != s_we || mem_oeA != s_oeA || mem_oeB != s_oeB ||
             mem_addr != s_addr || mem_din != s_din) n_chg++;
         if (int'(mem_we) + int'(mem_oeA) + int'(mem_oeB) > 1) n_excl++;
         if (mem_oeA) n_oeA++;
         if ((cpu_ack || ppu_ack || ldr_ack) && ack_ph == 0) ack_ph = i;
         n_cpu_ack += int'(cpu_ack);
         n_ppu_ack += int'(ppu_ack);
         n_ldr_ack += int'(ldr_ack);
      end
      if (mid) begin
         ldr_din ^= 8'hFF; cpu_din ^= 8'hFF; cpu_addr ^= 25'h1; ppu_addr ^= 25'h1;
      end
   endtask

   initial begin
      int g33, a33, ppu_slots, ppu_acks, we_after, ack_after;
      reset = 1'b1; slot_start = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = CPU_R_A; cpu_din = 8'h00;
      ppu_req = 1'b0; ppu_addr = PPU_A; ldr_req = 1'b0; ldr_addr = LDR_A; ldr_din = 8'h00;
      mem_doutA = 8'hA5; mem_doutB = 8'h77;
      repeat (3) tick;
      check("rst_strobes", {29'd0, mem_we, mem_oeA, mem_oeB}, 32'd0);
      check("rst_addr", 32'(mem_addr), 32'd0);
      check("rst_din", 32'(mem_din), 32'd0);
      check("rst_acks", {29'd0, cpu_ack, ppu_ack, ldr_ack}, 32'd0);
      check("rst_douts", {16'd0, cpu_dout, ppu_dout}, 32'd0);
      reset = 1'b0;
      tick;

      // no requests: idle slot
      run_slot(16, 0);
      check("idle0_grant", 32'(grant()), 32'd0);
      check("idle0_acks", 32'(n_cpu_ack + n_ppu_ack + n_ldr_ack), 32'd0);

      // CPU read
      cpu_req = 1'b1;
      run_slot(16, 0);
      cpu_req = 1'b0;
      check("cpurd_grant", 32'(grant()), 32'd2);
      check("cpurd_addr", 32'(s_addr), 32'(CPU_R_A));
      check("cpurd_oeA_cycles", 32'(n_oeA), 32'd16);
      check("cpurd_const", 32'(n_chg), 32'd0);
      check("cpurd_ack_count", 32'(n_cpu_ack), 32'd1);
      check("cpurd_ack_phase", 32'(ack_ph), 32'd9);
      check("cpurd_dout", 32'(cpu_dout), 32'hA5);

      // idle slot holds address, cpu_dout holds
      mem_doutA = 8'h3C;
      run_slot(16, 0);
      check("idle1_grant", 32'(grant()), 32'd0);
      check("idle1_addr_hold", 32'(s_addr), 32'(CPU_R_A));
      check("idle1_acks", 32'(n_cpu_ack + n_ppu_ack + n_ldr_ack), 32'd0);
      check("idle1_cpu_dout", 32'(cpu_dout), 32'hA5);

      // CPU write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = CPU_W_A; cpu_din = 8'h5A;
      run_slot(16, 0);
      cpu_req = 1'b0;
      check("cpuwr_strobes", {29'd0, s_we, s_oeA, s_oeB}, 32'b100);
      check("cpuwr_addr", 32'(s_addr), 32'(CPU_W_A));
      check("cpuwr_din", 32'(s_din), 32'h5A);
      check("cpuwr_ack", 32'(n_cpu_ack), 32'd1);
      check("cpuwr_dout_kept", 32'(cpu_dout), 32'hA5);
      run_slot(16, 0);

      // CPU vs PPU starvation pattern
      cpu_we = 1'b0; cpu_addr = CPU_R_A; cpu_req = 1'b1; ppu_req = 1'b1;
      for (int s = 0; s < 6; s++) begin
         run_slot(16, 0);
         check($sformatf("starve_grant%0d", s), 32'(grant()),
               (s == 2 || s == 5) ? 32'd2 : 32'd3);
         check($sformatf("starve_excl%0d", s), 32'(n_excl), 32'd0);
      end
      check("starve_ppu_dout", 32'(ppu_dout), 32'h77);

      // loader has top priority, mid-slot input changes ignored
      ldr_req = 1'b1; ldr_din = 8'hC3;
      for (int s = 0; s < 3; s++) begin
         run_slot(16, s == 1);
         check($sformatf("ldr_grant%0d", s), 32'(grant()), 32'd1);
         check($sformatf("ldr_din%0d", s), 32'(s_din), 32'hC3);
         check($sformatf("ldr_ack%0d", s), 32'(n_ldr_ack), 32'd1);
         check($sformatf("ldr_const%0d", s), 32'(n_chg), 32'd0);
      end
      ldr_req = 1'b0;
      run_slot(16, 0);
      check("post_ldr_cpu_wins", 32'(grant()), 32'd2);
      cpu_req = 1'b0; ppu_req = 1'b0;
      run_slot(16, 0);

      // forced refresh slot during a long PPU run
      ppu_req = 1'b1; ppu_slots = 0; ppu_acks = 0; g33 = -1; a33 = -1;
      for (int s = 1; s <= 40; s++) begin
         run_slot(16, 0);
         if (s == 33) begin
            g33 = grant();
            a33 = n_cpu_ack + n_ppu_ack + n_ldr_ack;
         end
         if (grant() == 3) ppu_slots++;
         ppu_acks += n_ppu_ack;
         if (s == 34) check("refresh_resume34", 32'(grant()), 32'd3);
      end
      check("refresh_slot33", 32'(g33), 32'd0);
      check("refresh_slot33_acks", 32'(a33), 32'd0);
      check("refresh_ppu_slots", 32'(ppu_slots), 32'd39);
      check("refresh_ppu_acks", 32'(ppu_acks), 32'd39);

      // short slot aborts PPU read
      mem_doutB = 8'h99;
      run_slot(6, 0);
      check("abort_grant", 32'(grant()), 32'd3);
      check("abort_no_ack", 32'(n_ppu_ack), 32'd0);
      check("abort_dout_held", 32'(ppu_dout), 32'h77);
      run_slot(16, 0);
      check("regrant_grant", 32'(grant()), 32'd3);
      check("regrant_ack", 32'(n_ppu_ack), 32'd1);
      check("regrant_ack_phase", 32'(ack_ph), 32'd9);
      check("regrant_dout", 32'(ppu_dout), 32'h99);
      ppu_req = 1'b0;
      run_slot(16, 0);

      // reset at phase 5 of a CPU write
      cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = CPU_W_A; cpu_din = 8'h66;
      slot_start = 1'b1;
      tick;
      slot_start = 1'b0;
      repeat (4) tick;
      check("midrst_we_before", 32'(mem_we), 32'd1);
      reset = 1'b1;
      tick;
      reset = 1'b0;
      check("midrst_strobes", {29'd0, mem_we, mem_oeA, mem_oeB}, 32'd0);
      check("midrst_addr_din", {mem_din[6:0], mem_addr}, 32'd0);
      check("midrst_douts", {16'd0, cpu_dout, ppu_dout}, 32'd0);
      we_after = 0; ack_after = int'(cpu_ack);
      for (int i = 0; i < 10; i++) begin
         tick;
         we_after  += int'(mem_we);
         ack_after += int'(cpu_ack);
      end
      check("midrst_no_ack", 32'(ack_after), 32'd0);
      check("midrst_no_we", 32'(we_after), 32'd0);
      run_slot(16, 0);
      check("midrst_regrant_addr", 32'(s_addr), 32'(CPU_W_A));
      check("midrst_regrant_we", 32'(s_we), 32'd1);
      check("midrst_regrant_ack", 32'(n_cpu_ack), 32'd1);
      cpu_req = 1'b0;
      tick;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
